// File: rtl/text_writer.sv
// Character-cell text writer: turns an ASCII stream into cursor-tracked character memory writes.
// Define TEXT_WRITER_CLEAR_EN to compile in the 0x0C clear-screen sweep (busy stays 0 without it).
module text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [6:0]  char_data,
  output logic        char_ready,
  output logic [11:0] char_addr,
  output logic [6:0]  char_value,
  output logic        char_we,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0] ASCII_BS = 7'h08;
  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_SP = 7'h20;
  localparam logic [6:0] ASCII_DEL = 7'h7F;

`ifdef TEXT_WRITER_CLEAR_EN
  localparam logic [6:0] ASCII_FF = 7'h0C;
  typedef enum logic {IDLE, CLEAR} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t     state;
  logic       printable;
  logic [4:0] row_next;

  assign char_ready = (state == IDLE);
  assign printable  = (char_data >= ASCII_SP) && (char_data != ASCII_DEL);
  assign row_next   = (cursor_row == ROW_LAST) ? 5'd0 : cursor_row + 5'd1;

`ifndef TEXT_WRITER_CLEAR_EN
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cursor_row <= '0;
      cursor_col <= '0;
      char_addr  <= '0;
      char_value <= '0;
      char_we    <= 1'b0;
`ifdef TEXT_WRITER_CLEAR_EN
      busy       <= 1'b0;
`endif
    end else begin
      char_we <= 1'b0;
      case (state)
        IDLE: begin
          if (char_valid) begin
            if (printable) begin
              char_we    <= 1'b1;
              char_addr  <= {cursor_row, cursor_col};
              char_value <= char_data;
              if (cursor_col == COL_LAST) begin
                cursor_col <= '0;
                cursor_row <= row_next;
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else begin
              case (char_data)
                ASCII_CR: cursor_col <= '0;
                ASCII_LF: begin
                  cursor_col <= '0;
                  cursor_row <= row_next;
                end
                ASCII_BS: begin
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    char_we    <= 1'b1;
                    char_addr  <= {cursor_row, cursor_col - 7'd1};
                    char_value <= ASCII_SP;
                  end
                end
`ifdef TEXT_WRITER_CLEAR_EN
                // First sweep write is issued on the accept edge so it lands the following cycle.
                ASCII_FF: begin
                  state      <= CLEAR;
                  busy       <= 1'b1;
                  char_we    <= 1'b1;
                  char_addr  <= '0;
                  char_value <= ASCII_SP;
                end
`endif
                default: ;
              endcase
            end
          end
        end
`ifdef TEXT_WRITER_CLEAR_EN
        CLEAR: begin
          // char_addr doubles as the sweep pointer: it holds the write being presented this cycle.
          if (char_addr == {ROW_LAST, COL_LAST}) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
          end else begin
            char_we    <= 1'b1;
            char_value <= ASCII_SP;
            if (char_addr[6:0] == COL_LAST)
              char_addr <= {char_addr[11:7] + 5'd1, 7'd0};
            else
              char_addr <= {char_addr[11:7], char_addr[6:0] + 7'd1};
          end
        end
`endif
      endcase
    end
  end

endmodule
